branch_tracker: RTL
===================

Name: branch_tracker

Overview:
- Pipeline-side client of the 2-bit saturating branch predictor.
- Accepts fetched branches, issues `request` pulses to the predictor and captures its `prediction`.
- Keeps outstanding predictions in an in-order queue and matches each against the resolved outcome.
- Drives the predictor's `result`/`taken` update pulses, flags mispredictions, flushes younger wrong-path entries, and keeps saturating statistics.

Parameters:
- DEPTH, 4, maximum outstanding (predicted, unresolved) branches; power of two, >=2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_branch  input  1  fetch presents a branch needing a prediction; accepted when fetch_ready=1.
- fetch_ready  output  1  tracker can accept a new branch.
- pred_request  output  1  request pulse to predictor.
- prediction  input  1  predictor's prediction, sampled the cycle after pred_request.
- pred_valid  output  1  one-cycle pulse: pred_taken_out is valid for fetch.
- pred_taken_out  output  1  captured prediction, 1 = taken.
- resolve_valid  input  1  execute stage resolves the oldest outstanding branch.
- resolve_taken  input  1  actual outcome.
- result  output  1  update pulse to predictor.
- taken  output  1  actual outcome sent with result.
- mispredict  output  1  one-cycle pulse: resolved outcome differed from stored prediction.
- outstanding  output  $clog2(DEPTH+1)  current queue occupancy.
- branch_count  output  CNT_W  resolved branches, saturating.
- miss_count  output  CNT_W  mispredictions, saturating.
- underflow_err  output  1  sticky: resolve_valid seen with empty queue.

Behaviour:
- Reset (rst_n=0, async):
  - FSM to IDLE; queue emptied.
  - All outputs 0, except fetch_ready=1.
  - Counters 0; underflow_err 0.
- Request FSM, states IDLE, REQ, CAPT:
  - IDLE: fetch_ready = (outstanding < DEPTH). fetch_branch && fetch_ready at edge N -> REQ.
  - REQ (cycle N+1): pred_request=1 (registered, exactly one cycle); fetch_ready=0 -> CAPT.
  - CAPT (cycle N+2): fetch_ready=0. At the edge ending CAPT, prediction is pushed to the queue tail. In cycle N+3, pred_valid=1 and pred_taken_out=captured value -> IDLE.
  - Accept-to-pred_valid latency is 3 cycles; back-to-back acceptance at most once per 3 cycles.
- Queue: circular buffer, DEPTH x 1 bit, head/tail pointers wrap modulo DEPTH. outstanding updates on the same edge as push/pop.
- Resolution (resolve_valid at edge M):
  - Queue non-empty: pop head. In cycle M+1: result=1, taken=resolve_taken; mispredict=1 iff resolve_taken != popped entry.
  - Queue empty: no pop, no result pulse; underflow_err set and held until reset.
  - Counters update at edge M: branch_count+1; miss_count+1 on mispredict. Each counter holds at all-ones (2^CNT_W-1) instead of wrapping.
- Mispredict flush, decided at edge M:
  - All remaining queue entries discarded; outstanding=0 at M+1.
  - If FSM is in REQ or CAPT, it returns to IDLE with no push and no pred_valid. A pred_request already driven is not retracted, and its prediction is ignored.
- Simultaneous events:
  - Push and pop on the same edge: both occur, occupancy unchanged, full is never reached by the coincident push.
  - Push and a mispredicting pop on the same edge: the push is dropped (flush wins).
  - resolve_valid in every cycle is legal; result pulses back-to-back.
- Full: fetch_ready=0 in IDLE while outstanding=DEPTH; fetch_branch ignored, no state change.
- Reset mid-operation: immediate return to reset values; no pulses emitted after rst_n falls.

Test Plan:
- Reset, then fetch_branch at cycle 1 with prediction=1 -> pred_request high cycle 2 only; pred_valid=1, pred_taken_out=1 at cycle 4; outstanding=1.
- Fill 4 branches (predictions 1,0,1,1), hold fetch_branch -> fetch_ready=0, outstanding=4. Resolve taken,0,1,1 -> four result pulses, taken=1,0,1,1, no mispredict; branch_count=4, miss_count=0, outstanding=0.
- 3 outstanding (1,1,0), resolve_taken=0 -> mispredict=1 one cycle, result=1, taken=0; outstanding=0 next cycle; miss_count=1; later resolve_valid -> underflow_err=1.
- Branch accepted, resolve mispredicts while FSM in CAPT -> no push, no pred_valid; FSM IDLE, fetch_ready=1 next cycle.
- CNT_W=2: 5 mispredicting resolutions -> branch_count and miss_count stop at 3.
- rst_n low asynchronously during REQ -> pred_request drops immediately; all outputs at reset values; fetch_ready=1.

Source files
------------

// File: rtl/branch_tracker.sv
// Pipeline-side client of a 2-bit branch predictor: requests and captures
// predictions, queues them in order, and checks them against resolved outcomes.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   fetch_branch / fetch_ready  branch needing a prediction / accept
//   pred_request, prediction    request pulse to predictor / its answer
//   pred_valid, pred_taken_out  captured prediction returned to fetch
//   resolve_valid/_taken        execute resolves the oldest branch
//   result, taken               update pulse and outcome to predictor
//   mispredict                  resolved outcome differed from prediction
//   outstanding                 queue occupancy
//   branch_count, miss_count    saturating statistics
//   underflow_err               sticky: resolve seen with empty queue
module branch_tracker #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       fetch_branch,
   output logic                       fetch_ready,
   output logic                       pred_request,
   input  logic                       prediction,
   output logic                       pred_valid,
   output logic                       pred_taken_out,
   input  logic                       resolve_valid,
   input  logic                       resolve_taken,
   output logic                       result,
   output logic                       taken,
   output logic                       mispredict,
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output logic [CNT_W-1:0]           branch_count,
   output logic [CNT_W-1:0]           miss_count,
   output logic                       underflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_CAPT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [OW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d;
   logic [CNT_W-1:0] mcnt_q, mcnt_d;
   logic             pv_q, pv_d;
   logic             pto_q, pto_d;
   logic             res_q, res_d;
   logic             tk_q, tk_d;
   logic             mis_q, mis_d;
   logic             und_q, und_d;

   logic empty, full, accept, pop, miss, push;

   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == OW'(DEPTH));
   assign pop    = resolve_valid && !empty;
   assign miss   = pop && (resolve_taken != mem_q[head_q]);
   // A mispredict flushes the wrong path, including a capture in flight.
   assign push   = (state_q == S_CAPT) && !miss;
   assign accept = fetch_branch && fetch_ready;

   assign fetch_ready    = (state_q == S_IDLE) && !full;
   assign pred_request   = (state_q == S_REQ);
   assign pred_valid     = pv_q;
   assign pred_taken_out = pto_q;
   assign result         = res_q;
   assign taken          = tk_q;
   assign mispredict     = mis_q;
   assign outstanding    = cnt_q;
   assign branch_count   = bcnt_q;
   assign miss_count     = mcnt_q;
   assign underflow_err  = und_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_REQ;
         S_REQ:   state_d = miss ? S_IDLE : S_CAPT;
         S_CAPT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[tail_q] = prediction;
      if (miss) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         head_d = head_q + PW'(pop);
         tail_d = tail_q + PW'(push);
         cnt_d  = cnt_q + OW'(push) - OW'(pop);
      end
   end

   always_comb begin
      bcnt_d = bcnt_q;
      mcnt_d = mcnt_q;
      if (pop && !(&bcnt_q)) bcnt_d = bcnt_q + CNT_W'(1);
      if (miss && !(&mcnt_q)) mcnt_d = mcnt_q + CNT_W'(1);
      pv_d  = push;
      pto_d = push ? prediction : pto_q;
      res_d = pop;
      tk_d  = pop && resolve_taken;
      mis_d = miss;
      und_d = und_q || (resolve_valid && empty);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mem_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         mcnt_q  <= '0;
         pv_q    <= 1'b0;
         pto_q   <= 1'b0;
         res_q   <= 1'b0;
         tk_q    <= 1'b0;
         mis_q   <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         mcnt_q  <= mcnt_d;
         pv_q    <= pv_d;
         pto_q   <= pto_d;
         res_q   <= res_d;
         tk_q    <= tk_d;
         mis_q   <= mis_d;
         und_q   <= und_d;
      end
   end

endmodule
